// File: rtl/fsm_visit_monitor.sv
// Per-state visit counter and sticky threshold alarm that watches the present-state bus of a benchmark FSM.
// Optional build macro VISIT_WINDOW_EN adds a WINDOW-cycle sliding reset of the visit counters.
module fsm_visit_monitor #(
  parameter int SW          = 4,
  parameter int NSTATES     = 11,
  parameter int CW          = 8,
  parameter int MODE_CYCLES = 0
`ifdef VISIT_WINDOW_EN
  ,
  parameter int WINDOW      = 256
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SW-1:0]      state_in,
  input  logic               state_vld,
  input  logic [NSTATES-1:0] watch_mask,
  input  logic [CW-1:0]      threshold,
  input  logic               clear,
  input  logic [SW-1:0]      rd_sel,
  output logic [CW-1:0]      rd_count,
  output logic               alarm,
  output logic [SW-1:0]      alarm_state,
  output logic               illegal
);

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [SW-1:0] LAST_CODE = SW'(NSTATES);

  typedef enum logic {
    IDLE,
    ARMED
  } ctl_t;

  ctl_t          ctl;
  logic [CW-1:0] cnt [1:NSTATES];
  logic [SW-1:0] prev_state;
  logic          prev_vld;

  logic          legal;
  logic          active;
  logic          entry;
  logic          inc;
  logic          watched;
  logic          wrap;
  logic          trip;
  logic [CW-1:0] cur;
  logic [CW-1:0] nxt;
  logic [CW-1:0] new_cnt;
  logic [CW-1:0] rd_val;

`ifdef VISIT_WINDOW_EN
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  logic [WW-1:0] win;
  assign wrap = (win == WW'(WINDOW - 1));
`else
  assign wrap = 1'b0;
`endif

  assign legal  = (state_in != '0) && (state_in <= LAST_CODE);
  // The IDLE->ARMED cycle itself is a counting cycle, so the first valid sample is never lost.
  assign active = (ctl == ARMED) || state_vld;
  assign entry  = state_vld && active && legal && ((state_in != prev_state) || !prev_vld);
  assign inc    = (MODE_CYCLES != 0) ? (state_vld && active && legal) : entry;

  // NOTE: every variable written here gets a default first, otherwise the
  // unmatched loop iterations would infer latches.
  always_comb begin
    cur     = '0;
    watched = 1'b0;
    rd_val  = '0;
    for (int s = 1; s <= NSTATES; s++) begin
      if (state_in == SW'(s)) begin
        cur     = cnt[s];
        watched = watch_mask[s-1];
      end
      if (rd_sel == SW'(s)) begin
        rd_val = cnt[s];
      end
    end
  end

  assign nxt     = (cur == CNT_MAX) ? CNT_MAX : cur + 1'b1;
  // A visit landing on the window rollover starts the new window at 1.
  assign new_cnt = wrap ? CW'(1) : nxt;
  assign trip    = inc && watched && (threshold != '0) && (new_cnt >= threshold);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl         <= IDLE;
      prev_state  <= '0;
      prev_vld    <= 1'b0;
      rd_count    <= '0;
      alarm       <= 1'b0;
      alarm_state <= '0;
      illegal     <= 1'b0;
      // NOTE: the counters are a small flop array, not a RAM, so resetting
      // them directly is both legal and required here.
      for (int s = 1; s <= NSTATES; s++) begin
        cnt[s] <= '0;
      end
`ifdef VISIT_WINDOW_EN
      win <= '0;
`endif
    end else begin
      prev_state <= state_in;
      prev_vld   <= state_vld;
      rd_count   <= rd_val;
      if (clear) begin
        ctl         <= IDLE;
        alarm       <= 1'b0;
        alarm_state <= '0;
        illegal     <= 1'b0;
        for (int s = 1; s <= NSTATES; s++) begin
          cnt[s] <= '0;
        end
`ifdef VISIT_WINDOW_EN
        win <= '0;
`endif
      end else begin
        if (ctl == IDLE && state_vld) begin
          ctl <= ARMED;
        end
`ifdef VISIT_WINDOW_EN
        win <= wrap ? '0 : win + 1'b1;
`endif
        for (int s = 1; s <= NSTATES; s++) begin
          if (wrap) begin
            cnt[s] <= '0;
          end
          if (inc && state_in == SW'(s)) begin
            cnt[s] <= new_cnt;
          end
        end
        if (trip) begin
          alarm <= 1'b1;
          if (!alarm) begin
            alarm_state <= state_in;
          end
        end
        if (state_vld && active && !legal) begin
          illegal <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fsm_visit_monitor.sv
// Randomized self-checking bench: two monitor instances (default and CW=3 cycle-counting)
// compared every cycle against a behavioural per-state visit model, plus pinned literal checks.
module tb_fsm_visit_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  state_in;
  logic        state_vld;
  logic [10:0] watch_mask;
  logic [7:0]  threshold;
  logic        clear;
  logic [3:0]  rd_sel;
  logic [7:0]  rd_count;
  logic        alarm;
  logic [3:0]  alarm_state;
  logic        illegal;
  logic [2:0]  rd_count_s;
  logic        alarm_s;
  logic [3:0]  alarm_state_s;
  logic        illegal_s;

  always #5 clk = ~clk;

`ifdef VISIT_WINDOW_EN
  fsm_visit_monitor #(.WINDOW(8)) dut (
`else
  fsm_visit_monitor dut (
`endif
    .clk(clk), .rst(rst), .state_in(state_in), .state_vld(state_vld),
    .watch_mask(watch_mask), .threshold(threshold), .clear(clear), .rd_sel(rd_sel),
    .rd_count(rd_count), .alarm(alarm), .alarm_state(alarm_state), .illegal(illegal)
  );

  fsm_visit_monitor #(.CW(3), .MODE_CYCLES(1)) dut_sat (
    .clk(clk), .rst(rst), .state_in(state_in), .state_vld(state_vld),
    .watch_mask(watch_mask), .threshold(threshold[2:0]), .clear(clear), .rd_sel(rd_sel),
    .rd_count(rd_count_s), .alarm(alarm_s), .alarm_state(alarm_state_s), .illegal(illegal_s)
  );

  // Model state, index 0 = default instance, index 1 = saturating cycle-counting instance.
  int mc   [2][16];
  int mprev[2];
  bit mpv  [2];
  bit mal  [2];
  int mas  [2];
  bit mil  [2];
  int mrd  [2];
  int mwin [2];
  int maxv [2] = '{255, 7};
  int modec[2] = '{0, 1};
`ifdef VISIT_WINDOW_EN
  int wsz  [2] = '{8, 256};
`else
  int wsz  [2] = '{0, 0};
`endif

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input int k);
    int s, thr, old, v;
    bit legal, inc, wrap;
    s     = int'(state_in);
    thr   = int'(threshold) & maxv[k];
    legal = (s >= 1) && (s <= 11);
    if (rst) begin
      for (int i = 0; i < 16; i++) mc[k][i] = 0;
      mprev[k] = 0; mpv[k] = 0; mal[k] = 0; mas[k] = 0; mil[k] = 0; mrd[k] = 0; mwin[k] = 0;
      return;
    end
    mrd[k] = (rd_sel >= 1 && rd_sel <= 11) ? mc[k][rd_sel] : 0;
    inc = state_vld && legal && (modec[k] == 1 || s != mprev[k] || !mpv[k]);
    if (clear) begin
      for (int i = 0; i < 16; i++) mc[k][i] = 0;
      mal[k] = 0; mas[k] = 0; mil[k] = 0; mwin[k] = 0;
    end else begin
      old  = mc[k][s];
      wrap = (wsz[k] != 0) && (mwin[k] == wsz[k] - 1);
      if (wsz[k] != 0) mwin[k] = wrap ? 0 : mwin[k] + 1;
      if (wrap) for (int i = 0; i < 16; i++) mc[k][i] = 0;
      if (inc) begin
        v = wrap ? 1 : ((old + 1 > maxv[k]) ? maxv[k] : old + 1);
        mc[k][s] = v;
        if (watch_mask[s-1] && thr != 0 && v >= thr) begin
          if (!mal[k]) mas[k] = s;
          mal[k] = 1;
        end
      end
      if (state_vld && !legal) mil[k] = 1;
    end
    mprev[k] = s;
    mpv[k]   = state_vld;
  endtask

  // One clock: advance the model at the edge, then compare every output 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("rd_count",      int'(rd_count),      mrd[0]);
    check("alarm",         int'(alarm),         int'(mal[0]));
    check("alarm_state",   int'(alarm_state),   mas[0]);
    check("illegal",       int'(illegal),       int'(mil[0]));
    check("rd_count_s",    int'(rd_count_s),    mrd[1]);
    check("alarm_s",       int'(alarm_s),       int'(mal[1]));
    check("alarm_state_s", int'(alarm_state_s), mas[1]);
    check("illegal_s",     int'(illegal_s),     int'(mil[1]));
  endtask

  task automatic drive(input int s, input bit v);
    state_in = 4'(s); state_vld = v; cyc();
  endtask

  initial begin
    int seq[6] = '{1, 3, 3, 3, 1, 3};
    int r;
    rst = 1'b1; clear = 1'b0; state_in = '0; state_vld = 1'b0;
    watch_mask = '0; threshold = '0; rd_sel = '0;
    cyc();
    check("reset_alarm", int'(alarm), 0);
    check("reset_rd", int'(rd_count), 0);
    rst = 1'b0;

    // Entry counting: 1,3,3,3,1,3 -> count[3]=2, count[1]=2.
    rd_sel = 4'd3;
    foreach (seq[i]) drive(seq[i], 1'b1);
    drive(0, 1'b0);
    check("entry_cnt3", int'(rd_count), 2);
    check("cycle_cnt3_s", int'(rd_count_s), 4);
    rd_sel = 4'd1;
    drive(0, 1'b0);
    check("entry_cnt1", int'(rd_count), 2);

    // Threshold alarm on state 11 at its fifth entry.
    watch_mask = 11'b100_0000_0000; threshold = 8'd5;
    for (int i = 0; i < 4; i++) begin drive(11, 1'b1); drive(2, 1'b1); end
    check("alarm_pre5", int'(alarm), 0);
    drive(11, 1'b1);
    check("alarm_5th", int'(alarm), 1);
    check("alarm_state_11", int'(alarm_state), 11);
    watch_mask = 11'b100_0000_0010; threshold = 8'd1;
    drive(2, 1'b1);
    check("first_trip_wins", int'(alarm_state), 11);

    // Saturation of the 3-bit cycle counter on state 4.
    rd_sel = 4'd4;
    for (int i = 0; i < 12; i++) drive(4, 1'b1);
    drive(0, 1'b0);
    check("sat_cnt4", int'(rd_count_s), 7);
    check("entry_cnt4", int'(rd_count), 1);

    // Illegal codes, then clear together with an entry.
    drive(0, 1'b1);
    check("illegal_zero", int'(illegal), 1);
    drive(13, 1'b1);
    rd_sel = 4'd5; clear = 1'b1;
    drive(5, 1'b1);
    clear = 1'b0;
    check("clear_alarm", int'(alarm), 0);
    check("clear_illegal", int'(illegal), 0);
    drive(5, 1'b1);
    drive(5, 1'b1);
    check("clear_no_reentry", int'(rd_count), 0);

    // Synchronous reset mid-run with the alarm set.
    watch_mask = '1; threshold = 8'd1;
    drive(2, 1'b1);
    check("alarm_before_rst", int'(alarm), 1);
    rst = 1'b1;
    drive(2, 1'b1);
    rst = 1'b0;
    check("rst_alarm", int'(alarm), 0);
    check("rst_alarm_state", int'(alarm_state), 0);
    watch_mask = '0; rd_sel = 4'd6;
    drive(6, 1'b1);
    drive(6, 1'b1);
    check("post_rst_first", int'(rd_count), 1);

`ifdef VISIT_WINDOW_EN
    // Window rollover: an entry on the rollover edge leaves that counter at 1.
    clear = 1'b1; drive(0, 1'b0); clear = 1'b0;
    watch_mask = '1; threshold = 8'd1;
    drive(1, 1'b1);
    for (int i = 0; i < 6; i++) drive(1, 1'b1);
    watch_mask = '0;
    drive(2, 1'b1);
    rd_sel = 4'd2; drive(0, 1'b0);
    check("win_load1", int'(rd_count), 1);
    rd_sel = 4'd1; drive(0, 1'b0);
    check("win_zeroed", int'(rd_count), 0);
    check("win_alarm_kept", int'(alarm), 1);
`endif

    // Randomized run against the model.
    for (int c = 0; c < 2500; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      clear = ($urandom_range(0, 89) == 0);
      state_vld = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 19);
      if (r < 8) state_in = state_in;
      else if (r < 18) state_in = 4'($urandom_range(1, 11));
      else state_in = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(12, 15));
      if ($urandom_range(0, 49) == 0) threshold = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 49) == 0) watch_mask = 11'($urandom);
      rd_sel = 4'($urandom_range(0, 15));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fsm_visit_monitor.md
Name: fsm_visit_monitor

Overview:
- Parametrised, reusable successor to the single hard-coded visit counter used in the benchmark FSMs.
- Observes the encoded present-state bus of any benchmark FSM (e.g. e6-class controllers), keeps one saturating visit counter per state, and raises a sticky alarm when any watched state's count reaches a programmable threshold.
- Sits beside the monitored FSM and has no effect on its outputs. Feeds the detection/evaluation harness.

Parameters:
- SW, 4, width of monitored state encoding.
- NSTATES, 11, number of states tracked; valid encodings are 1..NSTATES, all others are illegal.
- CW, 8, visit-counter width.
- MODE_CYCLES, 0, 0 = count state entries only; 1 = count every cycle spent in the state.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- state_in  input  SW  monitored FSM present state
- state_vld  input  1  state_in is meaningful this cycle
- watch_mask  input  NSTATES  bit i-1 enables alarm checking for state i
- threshold  input  CW  alarm level, sampled every cycle
- clear  input  1  synchronous clear of all counters and alarms
- rd_sel  input  SW  state index for readback
- rd_count  output  CW  registered count of state rd_sel (0 if rd_sel illegal)
- alarm  output  1  sticky threshold alarm
- alarm_state  output  SW  first state to trip the alarm
- illegal  output  1  sticky flag: state_vld with state_in outside 1..NSTATES

Behaviour:
- Reset (rst=1 at a clock edge):
  - All counters = 0, prev_state = 0, alarm = 0, alarm_state = 0, illegal = 0, rd_count = 0.
  - Reset dominates clear and all other inputs.
- Entry detection: entry = state_vld && legal(state_in) && (state_in != prev_state || prev_vld==0).
  - prev_state/prev_vld update every cycle from state_in/state_vld.
- Increment condition:
  - MODE_CYCLES=0: counter[state_in] increments on entry.
  - MODE_CYCLES=1: counter[state_in] increments on every cycle with state_vld && legal(state_in).
- Counters saturate at 2^CW-1 and never wrap.
- Alarm check uses the post-increment value. When watch_mask[s-1]=1, threshold != 0, and count reaches >= threshold:
  - alarm sets on the same edge as the counter update.
  - alarm_state latches s only if alarm was 0.
  - If alarm is already set, alarm_state holds; the first trip wins.
- threshold = 0 disables alarming.
- Lowering threshold below an existing count while the state is watched sets alarm on the next increment of that state, not retroactively.
- illegal sets when state_vld=1 and state_in is 0 or > NSTATES. No counter changes that cycle. prev_state still updates.
- clear=1: on that edge, all counters, alarm, alarm_state, and illegal go to 0; prev_state still updates. The increment for the clear cycle is discarded.
- rd_count: one-cycle latency; reflects the counter value after the previous edge's update.
- Simultaneous clear and entry: clear wins, count stays 0. The next entry is detected only on a real state change.
- Internal control: a 2-state FSM, IDLE/ARMED.
  - IDLE after reset or clear until the first state_vld.
  - ARMED thereafter.
  - Counting and illegal detection occur only in ARMED or on the IDLE->ARMED cycle.
  - The first valid sample counts as an entry.

Optional Feature:
VISIT_WINDOW_EN
- Defined:
  - Adds parameter WINDOW (default 256) and a free-running window counter that starts at 0 after reset or clear.
  - When the window counter reaches WINDOW-1, all visit counters zero on that edge; alarm, alarm_state, and illegal are kept.
  - An increment coinciding with the window rollover loads 1, not 0.
  - The alarm then means "threshold visits within one window".
- Undefined: no window counter; counters accumulate until reset or clear.

Test Plan:
- Entry counting: MODE_CYCLES=0, sequence 1,3,3,3,1,3 with state_vld=1 -> count[3]=2, count[1]=2, rd_count with rd_sel=3 reads 2 one cycle after the update.
- Threshold alarm: watch_mask=bit 10 (state 11), threshold=5, enter state 11 five times -> alarm rises on the edge of the 5th entry, alarm_state=11. A later trip on state 2 leaves alarm_state=11.
- Saturation: CW=3, MODE_CYCLES=1, hold state 4 for 12 cycles -> count[4]=7 and stays 7.
- Illegal/clear: state_in=0 with state_vld=1 -> illegal=1, no counts change. Then clear=1 simultaneous with an entry -> all counters 0, alarm=0, illegal=0.
- Sync reset mid-run: rst=1 for one cycle during counting with alarm set -> all outputs 0 after that edge. The first valid state afterwards counts as 1.
- VISIT_WINDOW_EN, WINDOW=8: entry on the rollover cycle -> that counter reads 1 afterwards; alarm set before the rollover remains 1.
